// File: rtl/as_lsu_pkg.sv
// as_lsu_pkg: shared constants, state type and alignment helpers for the
// rooth load/store unit.
//   INST_TYPE_IL / INST_TYPE_S : load and store opcodes
//   F3_*                       : load/store funct3 codes
//   lsu_state_e                : LSU FSM states (3-bit)
//   natural_off / is_misaligned: byte-offset helpers keyed on funct3[1:0]
package as_lsu_pkg;

  localparam logic [6:0] INST_TYPE_IL = 7'b0000011;
  localparam logic [6:0] INST_TYPE_S  = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    LSU_IDLE  = 3'd0,
    LSU_REQ   = 3'd1,
    LSU_WAIT  = 3'd2,
    LSU_DONE  = 3'd3,
    LSU_DRAIN = 3'd4
  } lsu_state_e;

  // funct3[1:0] gives access size for loads and stores alike: 00 byte, 01 half, 10 word.
  function automatic logic [1:0] natural_off(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b10:   return 2'b00;
      2'b01:   return {lo[1], 1'b0};
      default: return lo;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b10:   return lo != 2'b00;
      2'b01:   return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/as_lsu_if.sv
// as_lsu_if: req/gnt/rvalid data-memory bus.
//   master (LSU)   : drives req, we, addr, wdata, wstrb; receives gnt, rvalid, rdata
//   slave (memory) : the mirror image
interface as_lsu_if #(parameter int unsigned CPU_WIDTH = 32);
  logic                 req;
  logic                 we;
  logic [CPU_WIDTH-1:0] addr;
  logic [CPU_WIDTH-1:0] wdata;
  logic [3:0]           wstrb;
  logic                 gnt;
  logic                 rvalid;
  logic [CPU_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/as_lsu_align.sv
// as_lsu_align: combinational lane logic shared by the store and load paths.
//   funct3, off     : access type and (already aligned) byte offset
//   st_data         : raw store data -> wdata (lane-replicated), wstrb
//   rdata           : raw read word  -> ld_data (lane-selected, extended)
module as_lsu_align
  import as_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata = st_data;
    wstrb = 4'hF;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{st_data[7:0]}};
        wstrb = 4'b0001 << off;
      end
      2'b01: begin
        wdata = {2{st_data[15:0]}};
        wstrb = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (off)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_LB:   ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   ld_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  ld_data = {24'h0, byte_sel};
      F3_LHU:  ld_data = {16'h0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/as_lsu.sv
// as_lsu: memory-access stage load/store unit of the rooth core.
//   clk, rst_n        : core clock, asynchronous active-low reset
//   acess_mem_flag_i  : stage holds a load/store
//   inst_i            : instruction (opcode [6:0], funct3 [14:12])
//   alu_res_i         : effective byte address
//   rs2_data_i        : store data
//   flush_i           : kills the current access
//   mem               : as_lsu_if.master data-memory bus
//   lsu_busy_o        : stall request to the flow controller
//   load_data_o/load_valid_o : formatted load result, one-cycle valid pulse
//   misalign_o        : one-cycle misaligned-access pulse
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of
// silently aligning them.
module as_lsu
  import as_lsu_pkg::*;
#(
  parameter int unsigned CPU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 acess_mem_flag_i,
  input  logic [31:0]          inst_i,
  input  logic [CPU_WIDTH-1:0] alu_res_i,
  input  logic [CPU_WIDTH-1:0] rs2_data_i,
  input  logic                 flush_i,
  as_lsu_if.master             mem,
  output logic                 lsu_busy_o,
  output logic [CPU_WIDTH-1:0] load_data_o,
  output logic                 load_valid_o,
  output logic                 misalign_o
);

  lsu_state_e           state;
  logic [CPU_WIDTH-1:0] addr_q;
  logic [CPU_WIDTH-1:0] rs2_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic                 we_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  lo;
  logic        is_load, is_store, op_ok, start;
  logic [31:0] wdata_al, ld_fmt;
  logic [3:0]  wstrb_al;
  logic        unused_inst;

  assign opcode      = inst_i[6:0];
  assign funct3      = inst_i[14:12];
  assign lo          = alu_res_i[1:0];
  assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

  always_comb begin
    is_load  = (opcode == INST_TYPE_IL) && (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    is_store = (opcode == INST_TYPE_S)  && (funct3 inside {F3_SB, F3_SH, F3_SW});
    op_ok    = acess_mem_flag_i && (is_load || is_store) && !flush_i && (state == LSU_IDLE);
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign start      = op_ok && !is_misaligned(funct3, lo);
  assign misalign_o = op_ok && is_misaligned(funct3, lo);
`else
  assign start      = op_ok;
  assign misalign_o = 1'b0;
`endif

  // Store and load formatting both run off latched funct3/offset, so the bus
  // fields stay stable for the whole REQ phase regardless of upstream inputs.
  as_lsu_align u_align (
    .funct3  (f3_q),
    .off     (off_q),
    .st_data (rs2_q),
    .wdata   (wdata_al),
    .wstrb   (wstrb_al),
    .rdata   (mem.rdata),
    .ld_data (ld_fmt)
  );

  assign mem.req   = (state == LSU_REQ);
  assign mem.we    = we_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_al;
  assign mem.wstrb = (state == LSU_REQ && we_q) ? wstrb_al : '0;

  assign lsu_busy_o = start || (state inside {LSU_REQ, LSU_WAIT, LSU_DRAIN});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LSU_IDLE;
      addr_q       <= '0;
      rs2_q        <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      we_q         <= 1'b0;
      load_data_o  <= '0;
      load_valid_o <= 1'b0;
    end else begin
      load_valid_o <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (start) begin
            state  <= LSU_REQ;
            addr_q <= {alu_res_i[CPU_WIDTH-1:2], 2'b00};
            rs2_q  <= rs2_data_i;
            f3_q   <= funct3;
            off_q  <= natural_off(funct3, lo);
            we_q   <= is_store;
          end
        end
        LSU_REQ: begin
          if (flush_i)        state <= mem.gnt ? LSU_DRAIN : LSU_IDLE;
          else if (mem.gnt)   state <= LSU_WAIT;
        end
        LSU_WAIT: begin
          if (flush_i) begin
            state <= mem.rvalid ? LSU_IDLE : LSU_DRAIN;
          end else if (mem.rvalid) begin
            state <= LSU_DONE;
            if (!we_q) begin
              load_valid_o <= 1'b1;
              load_data_o  <= ld_fmt;
            end
          end
        end
        LSU_DONE:  state <= LSU_IDLE;
        LSU_DRAIN: if (mem.rvalid) state <= LSU_IDLE;
        default:   state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_as_lsu.sv
// tb_as_lsu: scoreboard bench for as_lsu. Expected bus requests and load
// results are queued when an access is driven; a memory model compares each
// requesting cycle against the queued request and a monitor compares load
// results as they appear. Honours LSU_MISALIGN_TRAP_EN.
`timescale 1ns/1ps
module tb_as_lsu;
  import as_lsu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flag, flush;
  logic [31:0] inst, alu, rs2;
  logic        busy, ld_valid, misalign;
  logic [31:0] ld_data;

  req_t        exp_req_q[$];
  logic [31:0] exp_ld_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_misalign = 0;
  int          gnt_dly = 0;
  int          rsp_dly = 0;
  logic [31:0] rdata_val = '0;

  always #5 clk = ~clk;

  as_lsu_if #(.CPU_WIDTH(32)) bus ();

  as_lsu #(.CPU_WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .acess_mem_flag_i (flag),
    .inst_i           (inst),
    .alu_res_i        (alu),
    .rs2_data_i       (rs2),
    .flush_i          (flush),
    .mem              (bus),
    .lsu_busy_o       (busy),
    .load_data_o      (ld_data),
    .load_valid_o     (ld_valid),
    .misalign_o       (misalign)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> {lo, 3'b000}) & 32'hFF;
    h = (w >> {lo[1], 4'b0000}) & 32'hFFFF;
    case (f3)
      F3_LB:   return b[7]  ? (b | 32'hFFFFFF00) : b;
      F3_LH:   return h[15] ? (h | 32'hFFFF0000) : h;
      F3_LBU:  return b;
      F3_LHU:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_SB:   return 4'b0001 << lo;
      F3_SH:   return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Memory model: grant after gnt_dly requesting cycles, respond rsp_dly
  // cycles after the cycle following grant.
  initial begin
    int   gcnt, rcnt;
    bit   pending;
    req_t e;
    gcnt = 0; rcnt = 0; pending = 0;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.gnt = 1'b0;
      bus.rvalid = 1'b0;
      if (pending) begin
        if (rcnt == rsp_dly) begin
          bus.rvalid = 1'b1;
          bus.rdata  = rdata_val;
          pending    = 0;
        end else rcnt++;
      end else if (bus.req) begin
        if (exp_req_q.size() == 0) check("unexp_req", bus.req, 1'b0);
        else begin
          e = exp_req_q[0];
          check("req_addr", bus.addr, e.addr);
          check("req_we", bus.we, e.we);
          if (e.we) begin
            check("req_wdata", bus.wdata, e.wdata);
            check("req_wstrb", bus.wstrb, e.wstrb);
          end
        end
        if (gcnt == gnt_dly) begin
          bus.gnt = 1'b1;
          gcnt = 0; rcnt = 0; pending = 1;
          if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
        end else gcnt++;
      end else gcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (exp_ld_q.size() == 0) check("unexp_load_valid", ld_valid, 1'b0);
      else check("load_data", ld_data, exp_ld_q.pop_front());
    end
    if (misalign) n_misalign++;
  end

  task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int gd, input int rsd, input string tag);
    req_t e;
    int   cyc;
    e.addr  = {a[31:2], 2'b00};
    e.we    = st;
    e.wdata = exp_wdata(f3, d);
    e.wstrb = exp_wstrb(f3, a[1:0]);
    exp_req_q.push_back(e);
    if (!st) exp_ld_q.push_back(exp_load(f3, a[1:0], rd));
    gnt_dly = gd; rsp_dly = rsd; rdata_val = rd;
    inst = {17'h0, f3, 5'd1, st ? INST_TYPE_S : INST_TYPE_IL};
    alu = a; rs2 = d; flag = 1'b1;
    cyc = 0;
    @(negedge clk);
    check({tag, "_req_c0"}, bus.req, 1'b0);
    while (busy && cyc < 64) begin
      cyc++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cyc, 3 + gd + rsd);
    check({tag, "_load_valid"}, ld_valid, !st);
    @(posedge clk); #1;
    flag = 1'b0;
    check({tag, "_req_consumed"}, exp_req_q.size(), 0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    req_t e;
    int   m0;
    flag = 1'b0; flush = 1'b0; inst = '0; alu = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_req", bus.req, 1'b0);
    check("rst_we", bus.we, 1'b0);
    check("rst_addr", bus.addr, 32'h0);
    check("rst_load_valid", ld_valid, 1'b0);
    check("rst_load_data", ld_data, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    idle_cycles(1);

    run_op(1'b0, F3_LW,  32'h100, 32'h0, 32'hDEADBEEF, 0, 0, "lw");
    run_op(1'b0, F3_LB,  32'h103, 32'h0, 32'h80123456, 0, 0, "lb");
    run_op(1'b0, F3_LBU, 32'h103, 32'h0, 32'h80123456, 0, 0, "lbu");
    run_op(1'b0, F3_LH,  32'h102, 32'h0, 32'h80123456, 0, 0, "lh");
    run_op(1'b0, F3_LHU, 32'h102, 32'h0, 32'h80123456, 0, 0, "lhu");
    run_op(1'b0, F3_LB,  32'h101, 32'h0, 32'h80123456, 0, 0, "lb1");
    run_op(1'b1, F3_SH,  32'h206, 32'h1234ABCD, 32'h0, 0, 0, "sh");
    run_op(1'b1, F3_SB,  32'h201, 32'h000000A5, 32'h0, 0, 0, "sb");
    run_op(1'b1, F3_SW,  32'h208, 32'h01020304, 32'h0, 0, 0, "sw");
    run_op(1'b0, F3_LW,  32'h400, 32'h0, 32'hCAFEF00D, 3, 1, "lw_slow");
    run_op(1'b1, F3_SB,  32'h402, 32'h0000007E, 32'h0, 2, 2, "sb_slow");

    // Unsupported funct3: no busy, no request, no misalign.
    inst = {17'h0, 3'b011, 5'd1, INST_TYPE_IL}; alu = 32'h104; flag = 1'b1;
    @(negedge clk);
    check("bad_f3_busy", busy, 1'b0);
    check("bad_f3_misalign", misalign, 1'b0);
    @(posedge clk); #1 flag = 1'b0;
    idle_cycles(3);

    // Flush in REQ before the grant arrives.
    e.addr = 32'h500; e.we = 1'b0; e.wdata = '0; e.wstrb = '0;
    exp_req_q.push_back(e);
    gnt_dly = 3; rsp_dly = 0;
    inst = {17'h0, F3_LW, 5'd1, INST_TYPE_IL}; alu = 32'h500; flag = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 flag = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_req_busy", busy, 1'b0);
    check("flush_req_req", bus.req, 1'b0);
    check("flush_req_nogrant", exp_req_q.size(), 1);
    if (exp_req_q.size() != 0) void'(exp_req_q.pop_front());
    idle_cycles(3);

    // Flush in WAIT, response arrives two cycles later and is discarded.
    e.addr = 32'h300;
    exp_req_q.push_back(e);
    gnt_dly = 0; rsp_dly = 2; rdata_val = 32'h55AA55AA;
    inst = {17'h0, F3_LW, 5'd1, INST_TYPE_IL}; alu = 32'h300; flag = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 flag = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("flush_wait_busy", busy, 1'b1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("drain_busy_a", busy, 1'b1);
    @(negedge clk);
    check("drain_busy_b", busy, 1'b1);
    @(negedge clk);
    check("drain_exit", busy, 1'b0);
    @(posedge clk); #1;
    run_op(1'b0, F3_LW, 32'h304, 32'h0, 32'h13572468, 0, 0, "lw_after_drain");

    // Misaligned word load.
    m0 = n_misalign;
`ifdef LSU_MISALIGN_TRAP_EN
    inst = {17'h0, F3_LW, 5'd1, INST_TYPE_IL}; alu = 32'h101; flag = 1'b1;
    @(negedge clk);
    check("mis_pulse", misalign, 1'b1);
    check("mis_busy", busy, 1'b0);
    @(posedge clk); #1 flag = 1'b0;
    idle_cycles(3);
    check("mis_count", n_misalign - m0, 1);
`else
    run_op(1'b0, F3_LW, 32'h101, 32'h0, 32'h89ABCDEF, 0, 0, "lw_mis");
    check("mis_count", n_misalign - m0, 0);
`endif

    idle_cycles(4);
    check("end_req_q", exp_req_q.size(), 0);
    check("end_ld_q", exp_ld_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
